// File: rtl/matrix_feeder.sv
`default_nettype none
// ============================================================================
// Module      : matrix_feeder
// Description : Serially loads vector A and matrix B, fires the multiplier
//               once, captures its result and streams it out element-wise.
//               Optional macro MATRIX_FEEDER_SATCNT_EN adds the sat_count port.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_feeder #(
    parameter int DATA_SIZE   = 16,
    parameter int COLUMN_SIZE = 16,
    parameter int ROW_SIZE    = 16
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_SIZE-1:0]                  in_data,
    output logic                                  mat_enable,
    output logic [DATA_SIZE*COLUMN_SIZE-1:0]      mat_datsA,
    output logic [DATA_SIZE*COLUMN_SIZE*ROW_SIZE-1:0] mat_datsB,
    input  logic [DATA_SIZE*COLUMN_SIZE-1:0]      mat_datsOut,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_SIZE-1:0]                  out_data,
    output logic                                  out_last,
    output logic                                  busy
`ifdef MATRIX_FEEDER_SATCNT_EN
    ,
    output logic [7:0]                            sat_count
`endif
);

    // One counter indexes A, B and the drain position; it must reach the last B word.
    localparam int c_CNT_W = (COLUMN_SIZE * ROW_SIZE > 1) ? $clog2(COLUMN_SIZE * ROW_SIZE) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_A = c_CNT_W'(COLUMN_SIZE - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_B = c_CNT_W'(COLUMN_SIZE * ROW_SIZE - 1);

    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_FIRE    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t                                  r_state;
    state_t                                  w_state_next;
    logic [c_CNT_W-1:0]                      r_cnt;
    logic [DATA_SIZE*COLUMN_SIZE-1:0]        r_dats_a;
    logic [DATA_SIZE*COLUMN_SIZE*ROW_SIZE-1:0] r_dats_b;
    logic [DATA_SIZE*COLUMN_SIZE-1:0]        r_result;
    logic                                    w_in_xfer;
    logic                                    w_out_xfer;

    assign in_ready   = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign busy       = (r_state != S_LOAD_A);
    assign mat_enable = (r_state == S_FIRE);
    assign out_valid  = (r_state == S_DRAIN);
    assign out_last   = (r_state == S_DRAIN) && (r_cnt == c_LAST_A);
    assign out_data   = (r_state == S_DRAIN) ? r_result[int'(r_cnt)*DATA_SIZE +: DATA_SIZE]
                                             : '0;
    assign mat_datsA  = r_dats_a;
    assign mat_datsB  = r_dats_b;
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LOAD_A:  if (w_in_xfer && (r_cnt == c_LAST_A)) w_state_next = S_LOAD_B;
            S_LOAD_B:  if (w_in_xfer && (r_cnt == c_LAST_B)) w_state_next = S_FIRE;
            S_FIRE:    w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = S_DRAIN;
            S_DRAIN:   if (w_out_xfer && (r_cnt == c_LAST_A)) w_state_next = S_LOAD_A;
            default:   w_state_next = S_LOAD_A;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_LOAD_A;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Any state change restarts the index, so each phase begins at element 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_cnt <= '0;
        end else if (w_in_xfer || w_out_xfer) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_dats_a <= '0;
            r_dats_b <= '0;
            r_result <= '0;
        end else begin
            if ((r_state == S_LOAD_A) && w_in_xfer) begin
                r_dats_a[int'(r_cnt)*DATA_SIZE +: DATA_SIZE] <= in_data;
            end
            if ((r_state == S_LOAD_B) && w_in_xfer) begin
                r_dats_b[int'(r_cnt)*DATA_SIZE +: DATA_SIZE] <= in_data;
            end
            if (r_state == S_CAPTURE) begin
                r_result <= mat_datsOut;
            end
        end
    end

`ifdef MATRIX_FEEDER_SATCNT_EN
    logic [31:0] w_ones;
    logic [7:0]  r_sat_count;

    always_comb begin
        w_ones = 32'd0;
        for (int i = 0; i < COLUMN_SIZE; i++) begin
            if (mat_datsOut[i*DATA_SIZE +: DATA_SIZE] == {DATA_SIZE{1'b1}}) begin
                w_ones = w_ones + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sat_count <= 8'd0;
        end else if (r_state == S_CAPTURE) begin
            r_sat_count <= (w_ones > 32'd255) ? 8'hFF : w_ones[7:0];
        end
    end

    assign sat_count = r_sat_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_feeder
// Description : Directed self-checking bench for matrix_feeder with a
//               registered multiplier stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_feeder;

    localparam int DW = 16;
    localparam int CS = 16;
    localparam int RS = 16;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         in_data;
    logic                  mat_enable;
    logic [DW*CS-1:0]      mat_datsA;
    logic [DW*CS*RS-1:0]   mat_datsB;
    logic [DW*CS-1:0]      mat_datsOut = '0;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         out_data;
    logic                  out_last;
    logic                  busy;
`ifdef MATRIX_FEEDER_SATCNT_EN
    logic [7:0]            sat_count;
`endif

    logic [DW-1:0] stub_elem [CS];
    int n_tests = 0;
    int n_fail  = 0;
    int en_count = 0;
    int xfer_count = 0;
    int e0;
    int x0;

    matrix_feeder #(.DATA_SIZE(DW), .COLUMN_SIZE(CS), .ROW_SIZE(RS)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mat_enable  (mat_enable),
        .mat_datsA   (mat_datsA),
        .mat_datsB   (mat_datsB),
        .mat_datsOut (mat_datsOut),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy)
`ifdef MATRIX_FEEDER_SATCNT_EN
        ,
        .sat_count   (sat_count)
`endif
    );

    always #5 clock = ~clock;

    // Registered multiplier stub plus event counters.
    always @(posedge clock) begin
        if (mat_enable) begin
            for (int i = 0; i < CS; i++) mat_datsOut[i*DW +: DW] <= stub_elem[i];
            en_count <= en_count + 1;
        end
        if (in_valid && in_ready) xfer_count <= xfer_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready), 32'd1);
        chk({tag, "_busy"},       32'(busy), 32'd0);
        chk({tag, "_mat_enable"}, 32'(mat_enable), 32'd0);
        chk({tag, "_out_valid"},  32'(out_valid), 32'd0);
        chk({tag, "_out_last"},   32'(out_last), 32'd0);
        chk({tag, "_out_data"},   32'(out_data), 32'd0);
        chk({tag, "_datsA_zero"}, 32'(mat_datsA === '0), 32'd1);
        chk({tag, "_datsB_zero"}, 32'(mat_datsB === '0), 32'd1);
`ifdef MATRIX_FEEDER_SATCNT_EN
        chk({tag, "_sat_count"},  32'(sat_count), 32'd0);
`endif
    endtask

    task automatic send(input logic [DW-1:0] d);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (t >= 20) begin
            n_tests++;
            n_fail++;
            $error("FAIL send_timeout: observed in_ready 0 expected 1");
        end
        @(negedge clock);
    endtask

    task automatic load_frame(input logic [DW-1:0] a_base, input logic [DW-1:0] b_base,
                              input int n_b, input bit gap);
        for (int k = 0; k < CS; k++) begin
            if (gap) begin
                in_valid = 1'b0;
                @(negedge clock);
            end
            send(DW'(a_base + DW'(k)));
        end
        for (int k = 0; k < n_b; k++) begin
            if (gap) begin
                in_valid = 1'b0;
                @(negedge clock);
            end
            send(DW'(b_base + DW'(k)));
        end
    endtask

    task automatic drain(input int stall_at, input bit poke);
        out_ready = 1'b1;
        if (poke) begin
            in_valid = 1'b1;
            in_data  = 16'hDEAD;
        end
        for (int j = 0; j < CS; j++) begin
            if (j == stall_at) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clock);
                    chk("stall_out_valid", 32'(out_valid), 32'd1);
                    chk("stall_out_data",  32'(out_data),  32'(stub_elem[j]));
                    chk("stall_out_last",  32'(out_last),  32'd0);
                end
                out_ready = 1'b1;
            end
            chk("drain_out_valid", 32'(out_valid), 32'd1);
            chk("drain_out_data",  32'(out_data),  32'(stub_elem[j]));
            chk("drain_out_last",  32'(out_last),  32'(j == CS - 1));
            chk("drain_in_ready",  32'(in_ready),  32'd0);
            @(negedge clock);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_drain_busy",      32'(busy),      32'd0);
        chk("post_drain_in_ready",  32'(in_ready),  32'd1);
        chk("post_drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < CS; i++) stub_elem[i] = DW'(16'h0100 + i);

        // Reset state
        repeat (2) @(negedge clock);
        check_idle("reset");
        reset = 1'b1;
        @(negedge clock);

        // Frame 1: continuous load, stall during drain at j = 3
        e0 = en_count;
        x0 = xfer_count;
        load_frame(16'h0001, 16'h1000, CS * RS, 1'b0);
        in_valid = 1'b0;
        chk("f1_xfers",      32'(xfer_count - x0), 32'd272);
        chk("f1_datsA_0",    32'(mat_datsA[15:0]), 32'h0001);
        chk("f1_datsA_15",   32'(mat_datsA[16*15 +: 16]), 32'h0010);
        chk("f1_datsB_0",    32'(mat_datsB[15:0]), 32'h1000);
        chk("f1_datsB_255",  32'(mat_datsB[16*255 +: 16]), 32'h10FF);
        chk("f1_fire_en",    32'(mat_enable), 32'd1);
        chk("f1_fire_ready", 32'(in_ready), 32'd0);
        chk("f1_fire_busy",  32'(busy), 32'd1);
        @(negedge clock);
        chk("f1_capture_en", 32'(mat_enable), 32'd0);
        chk("f1_en_pulses",  32'(en_count - e0), 32'd1);
        chk("f1_capture_ov", 32'(out_valid), 32'd0);
        @(negedge clock);
        drain(3, 1'b0);
        chk("f1_en_total",   32'(en_count - e0), 32'd1);
        chk("f1_hold_A",     32'(mat_datsA[15:0]), 32'h0001);
        chk("f1_hold_B",     32'(mat_datsB[16*255 +: 16]), 32'h10FF);

        // Frame 2: in_valid toggled during load, saturating elements, in_valid poked in drain
        stub_elem[2]  = 16'hFFFF;
        stub_elem[7]  = 16'hFFFF;
        stub_elem[11] = 16'hFFFF;
        e0 = en_count;
        x0 = xfer_count;
        load_frame(16'h0101, 16'h2000, CS * RS, 1'b1);
        in_valid = 1'b0;
        chk("f2_xfers",      32'(xfer_count - x0), 32'd272);
        chk("f2_datsA_0",    32'(mat_datsA[15:0]), 32'h0101);
        chk("f2_datsB_255",  32'(mat_datsB[16*255 +: 16]), 32'h20FF);
        chk("f2_fire_en",    32'(mat_enable), 32'd1);
        @(negedge clock);
        @(negedge clock);
        chk("f2_en_pulses",  32'(en_count - e0), 32'd1);
`ifdef MATRIX_FEEDER_SATCNT_EN
        chk("f2_sat_count",  32'(sat_count), 32'd3);
`endif
        x0 = xfer_count;
        drain(-1, 1'b1);
        chk("f2_drain_noxfer", 32'(xfer_count - x0), 32'd0);

        // Frame 3: reset asserted at LOAD_B k = 100
        load_frame(16'h0301, 16'h3000, 100, 1'b0);
        e0 = en_count;
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check_idle("abort");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        chk("abort_no_enable", 32'(en_count - e0), 32'd0);
        chk("abort_busy",      32'(busy), 32'd0);
        send(16'h00AA);
        in_valid = 1'b0;
        chk("reload_A0",       32'(mat_datsA[15:0]), 32'h00AA);
        chk("reload_A1",       32'(mat_datsA[31:16]), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
